// File: rtl/lfsr_pkg.sv
// Shared types, default constants and the Galois step function for the LFSR
// random-number blocks.
package lfsr_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } fill_state_t;

  localparam logic [31:0] DEFAULT_TAPS = 32'h80200003;
  localparam logic [31:0] DEFAULT_SEED = 32'hAEAF696C;

  // Widest state the step helper supports.
  localparam int LFSR_MAX_W = 64;

  // Narrower states are passed zero-extended, so the right shift never pulls
  // stray ones into the used bits and the caller simply truncates the result.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps
  );
    return state[0] ? ((state >> 1) ^ taps) : (state >> 1);
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Galois LFSR state register with seed load and zero-state recovery.
// Exposes only the low candidate bits so a wrapper can sample it directly.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int                LFSR_W   = 32,
  parameter logic [LFSR_W-1:0] TAPS     = DEFAULT_TAPS[LFSR_W-1:0],
  parameter logic [LFSR_W-1:0] SEED     = DEFAULT_SEED[LFSR_W-1:0],
  parameter int                SAMPLE_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_enable,
  input  logic                i_seedLoad,
  input  logic [LFSR_W-1:0]   i_seedIn,
  output logic [SAMPLE_W-1:0] o_cand,
  output logic                o_stateOk
);

  logic [LFSR_W-1:0] r_state;
  logic [LFSR_W-1:0] w_stepped;
  logic [LFSR_W-1:0] w_seedSafe;

  assign w_stepped  = LFSR_W'(lfsr_step(LFSR_MAX_W'(r_state), LFSR_MAX_W'(TAPS)));
  assign w_seedSafe = (i_seedIn == '0) ? SEED : i_seedIn;

  // A zero state would lock the LFSR forever, so it is replaced by SEED on
  // any edge, even while stepping is disabled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= SEED;
    end else if (i_seedLoad) begin
      r_state <= w_seedSafe;
    end else if (r_state == '0) begin
      r_state <= SEED;
    end else if (i_enable) begin
      r_state <= w_stepped;
    end
  end

  assign o_cand    = r_state[SAMPLE_W-1:0];
  assign o_stateOk = (r_state != '0);

endmodule

// File: rtl/lfsr_rand_stream.sv
// Pseudo-random sample stream: LFSR candidates filtered by rejection sampling
// into a one-entry valid/ready output register with a saturating fallback.
module lfsr_rand_stream
  import lfsr_pkg::*;
#(
  parameter int                LFSR_W    = 32,
  parameter logic [LFSR_W-1:0] TAPS      = DEFAULT_TAPS[LFSR_W-1:0],
  parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED[LFSR_W-1:0],
  parameter int                SAMPLE_W  = 4,
  parameter int                OUT_W     = 32,
  parameter int                MAX_TRIES = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                seed_load,
  input  logic [LFSR_W-1:0]   seed_in,
  input  logic                mode,
  input  logic [SAMPLE_W-1:0] limit,
  output logic                rand_valid,
  input  logic                rand_ready,
  output logic [OUT_W-1:0]    rand_out,
  output logic                sat_flag
);

  localparam int TRIES_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRIES_W-1:0]  LAST_TRY = TRIES_W'(MAX_TRIES - 1);
  localparam logic [SAMPLE_W-1:0] MOST_NEG = SAMPLE_W'(1) << (SAMPLE_W - 1);

  fill_state_t         r_fsm;
  fill_state_t         w_fsmNext;
  logic [TRIES_W-1:0]  r_tries;
  logic [TRIES_W-1:0]  w_triesNext;
  logic [OUT_W-1:0]    r_out;
  logic [OUT_W-1:0]    w_outNext;
  logic                r_sat;
  logic                w_satNext;
  logic [SAMPLE_W-1:0] w_cand;
  logic                w_stateOk;
  logic                w_accept;
  logic [OUT_W-1:0]    w_candExt;
  logic                w_handshake;
  logic                w_doEval;

  lfsr_core #(
    .LFSR_W  (LFSR_W),
    .TAPS    (TAPS),
    .SEED    (SEED),
    .SAMPLE_W(SAMPLE_W)
  ) u_core (
    .clock     (clock),
    .reset     (reset),
    .i_enable  (enable),
    .i_seedLoad(seed_load),
    .i_seedIn  (seed_in),
    .o_cand    (w_cand),
    .o_stateOk (w_stateOk)
  );

  // Signed mode only rejects the most-negative code so the range is symmetric.
  always_comb begin
    w_accept  = mode ? (w_cand != MOST_NEG) : (w_cand <= limit);
    w_candExt = mode ? OUT_W'(signed'(w_cand)) : OUT_W'(w_cand);
  end

  assign w_handshake = (r_fsm == FULL) && rand_ready;

  // A handshake with enable high re-evaluates in the same cycle, which lets
  // the register deliver one sample per clock when candidates keep passing.
  always_comb begin
    w_fsmNext   = r_fsm;
    w_triesNext = r_tries;
    w_outNext   = r_out;
    w_satNext   = r_sat;
    w_doEval    = 1'b0;
    if (seed_load) begin
      w_fsmNext   = EMPTY;
      w_triesNext = '0;
      w_satNext   = 1'b0;
    end else if (r_fsm == FULL) begin
      if (w_handshake) begin
        if (enable && w_stateOk) begin
          w_doEval = 1'b1;
        end else begin
          w_fsmNext = EMPTY;
        end
      end
    end else if (enable && w_stateOk) begin
      w_doEval = 1'b1;
    end
    if (w_doEval) begin
      if (w_accept) begin
        w_outNext   = w_candExt;
        w_satNext   = 1'b0;
        w_fsmNext   = FULL;
        w_triesNext = '0;
      end else if (r_tries == LAST_TRY) begin
        w_outNext   = '0;
        w_satNext   = 1'b1;
        w_fsmNext   = FULL;
        w_triesNext = '0;
      end else begin
        w_fsmNext   = EMPTY;
        w_triesNext = r_tries + TRIES_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fsm   <= EMPTY;
      r_tries <= '0;
      r_out   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_fsm   <= w_fsmNext;
      r_tries <= w_triesNext;
      r_out   <= w_outNext;
      r_sat   <= w_satNext;
    end
  end

  assign rand_valid = (r_fsm == FULL);
  assign rand_out   = r_out;
  assign sat_flag   = r_sat;

endmodule

// File: tb/tb_lfsr_rand_stream.sv
// Directed bench for lfsr_rand_stream: default instance plus a MAX_TRIES=2
// instance sharing the same stimulus to reach the fallback path quickly.
module tb_lfsr_rand_stream;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        seed_load;
  logic [31:0] seed_in;
  logic        mode;
  logic [3:0]  limit;
  logic        rand_ready;
  logic        rand_valid;
  logic [31:0] rand_out;
  logic        sat_flag;
  logic        rand_valid2;
  logic [31:0] rand_out2;
  logic        sat_flag2;

  int total = 0;
  int bad   = 0;

  lfsr_rand_stream dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .mode      (mode),
    .limit     (limit),
    .rand_valid(rand_valid),
    .rand_ready(rand_ready),
    .rand_out  (rand_out),
    .sat_flag  (sat_flag)
  );

  lfsr_rand_stream #(.MAX_TRIES(2)) dut2 (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .mode      (mode),
    .limit     (limit),
    .rand_valid(rand_valid2),
    .rand_ready(rand_ready),
    .rand_out  (rand_out2),
    .sat_flag  (sat_flag2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives a seed load for one edge; returns at the following negedge with
  // seed_load low again.
  task automatic applyStimulus(input logic [31:0] seed, input logic m,
                               input logic [3:0] lim);
    seed_load = 1'b1;
    seed_in   = seed;
    mode      = m;
    limit     = lim;
    @(negedge clock);
    seed_load = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    seed_load  = 1'b0;
    seed_in    = 32'h0;
    mode       = 1'b0;
    limit      = 4'h0;
    rand_ready = 1'b0;
    #1;
    checkOutput("reset_valid", 32'(rand_valid), 32'h0);
    checkOutput("reset_out",   rand_out,        32'h0);
    checkOutput("reset_sat",   32'(sat_flag),   32'h0);

    @(negedge clock);
    reset      = 1'b0;
    enable     = 1'b1;
    rand_ready = 1'b1;

    // Seed 1, signed mode: consecutive samples 1, 3, 2
    @(negedge clock);
    applyStimulus(32'h1, 1'b1, 4'h0);
    checkOutput("seed1_flush_valid", 32'(rand_valid), 32'h0);
    @(negedge clock);
    checkOutput("seed1_valid", 32'(rand_valid), 32'h1);
    checkOutput("seed1_s0", rand_out, 32'h1);
    @(negedge clock);
    checkOutput("seed1_s1", rand_out, 32'h3);
    @(negedge clock);
    checkOutput("seed1_s2", rand_out, 32'h2);
    checkOutput("seed1_valid2", 32'(rand_valid), 32'h1);

    // Seed 8: 1000 rejected, then 4 accepted one cycle later
    applyStimulus(32'h8, 1'b1, 4'h0);
    checkOutput("seed8_flush", 32'(rand_valid), 32'h0);
    @(negedge clock);
    checkOutput("seed8_reject", 32'(rand_valid), 32'h0);
    @(negedge clock);
    checkOutput("seed8_valid", 32'(rand_valid), 32'h1);
    checkOutput("seed8_out", rand_out, 32'h4);

    // Seed F: sign extension vs zero extension
    applyStimulus(32'hF, 1'b1, 4'h0);
    @(negedge clock);
    checkOutput("seedF_signed", rand_out, 32'hFFFF_FFFF);
    checkOutput("seedF_sat", 32'(sat_flag), 32'h0);
    applyStimulus(32'hF, 1'b0, 4'hF);
    @(negedge clock);
    checkOutput("seedF_unsigned", rand_out, 32'h0000_000F);

    // MAX_TRIES=2 instance: 1 and 3 rejected against limit 0, then fallback
    applyStimulus(32'h1, 1'b0, 4'h0);
    @(negedge clock);
    checkOutput("fb_wait_valid", 32'(rand_valid2), 32'h0);
    @(negedge clock);
    checkOutput("fb_valid", 32'(rand_valid2), 32'h1);
    checkOutput("fb_out", rand_out2, 32'h0);
    checkOutput("fb_sat", 32'(sat_flag2), 32'h1);
    limit = 4'hF;
    @(negedge clock);
    checkOutput("fb_next_out", rand_out2, 32'h2);
    checkOutput("fb_next_sat", 32'(sat_flag2), 32'h0);

    // seed_in = 0 loads SEED, whose low nibble C is -4 in signed mode
    applyStimulus(32'h0, 1'b1, 4'h0);
    @(negedge clock);
    checkOutput("seed0_out", rand_out, 32'hFFFF_FFFC);

    // Seed load while FULL and not ready flushes the register
    rand_ready = 1'b0;
    applyStimulus(32'h1, 1'b1, 4'h0);
    checkOutput("flush_full_valid", 32'(rand_valid), 32'h0);
    @(negedge clock);
    checkOutput("hold_valid", 32'(rand_valid), 32'h1);
    checkOutput("hold_out", rand_out, 32'h1);
    mode  = 1'b0;
    limit = 4'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput("hold_stable_out", rand_out, 32'h1);
      checkOutput("hold_stable_valid", 32'(rand_valid), 32'h1);
    end

    // Asynchronous reset mid-cycle clears outputs immediately
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_valid", 32'(rand_valid), 32'h0);
    checkOutput("midreset_out", rand_out, 32'h0);
    checkOutput("midreset_sat2", 32'(sat_flag2), 32'h0);
    @(negedge clock);
    reset      = 1'b0;
    mode       = 1'b1;
    rand_ready = 1'b1;
    @(negedge clock);
    checkOutput("postreset_out", rand_out, 32'hFFFF_FFFC);

    // enable=0: handshake drains FULL, LFSR frozen at 0x5757B4B6
    enable = 1'b0;
    @(negedge clock);
    checkOutput("drain_valid", 32'(rand_valid), 32'h0);
    @(negedge clock);
    checkOutput("frozen_valid", 32'(rand_valid), 32'h0);
    enable = 1'b1;
    @(negedge clock);
    checkOutput("resume_valid", 32'(rand_valid), 32'h1);
    checkOutput("resume_out", rand_out, 32'h6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
